// File: rtl/ones_fill.sv
// ones_fill: builds a WIDTH-bit thermometer word with min(count,WIDTH) low ones; go/done handshake, no abort.
// Latency 2*N+2 cycles from go to done; go is ignored while busy, and the result holds in COMPLETE until the next go.
module ones_fill #(
  parameter int WIDTH     = 8,
  parameter int CNT_WIDTH = $clog2(WIDTH + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 go,
  input  logic [CNT_WIDTH-1:0] count,
  output logic [WIDTH-1:0]     result,
  output logic                 busy,
  output logic                 done
);

  typedef enum logic [1:0] {
    START,
    CHECK_ZERO,
    FILL,
    COMPLETE
  } state_t;

  localparam logic [CNT_WIDTH-1:0] WIDTH_C = CNT_WIDTH'(WIDTH);

  state_t               state_r;
  logic [CNT_WIDTH-1:0] cnt_r;
  logic [WIDTH-1:0]     result_r;
  logic                 busy_r;
  logic                 done_r;

  logic [CNT_WIDTH-1:0] cnt_load;

  // Saturate so the shift register can never push a one out of the top.
  assign cnt_load = (count > WIDTH_C) ? WIDTH_C : count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r  <= START;
      cnt_r    <= '0;
      result_r <= '0;
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
    end else begin
      case (state_r)
        START, COMPLETE: begin
          if (go) begin
            cnt_r    <= cnt_load;
            result_r <= '0;
            state_r  <= CHECK_ZERO;
            busy_r   <= 1'b1;
            done_r   <= 1'b0;
          end
        end
        CHECK_ZERO: begin
          if (cnt_r == '0) begin
            state_r <= COMPLETE;
            busy_r  <= 1'b0;
            done_r  <= 1'b1;
          end else begin
            state_r <= FILL;
          end
        end
        FILL: begin
          result_r <= {result_r[WIDTH-2:0], 1'b1};
          cnt_r    <= cnt_r - 1'b1;
          state_r  <= CHECK_ZERO;
        end
        default: begin
          state_r <= START;
          busy_r  <= 1'b0;
          done_r  <= 1'b0;
        end
      endcase
    end
  end

  assign result = result_r;
  assign busy   = busy_r;
  assign done   = done_r;

endmodule

// File: tb/tb_ones_fill.sv
// Directed bench for ones_fill (WIDTH=8): latency, fill value, saturation, ignored inputs, async reset.
module tb_ones_fill;

  logic       clk;
  logic       rst;
  logic       go;
  logic [3:0] count;
  logic [7:0] result;
  logic       busy;
  logic       done;

  int n_tests = 0;
  int n_fail  = 0;

  ones_fill #(.WIDTH(8)) dut (
    .clk    (clk),
    .rst    (rst),
    .go     (go),
    .count  (count),
    .result (result),
    .busy   (busy),
    .done   (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Pulses go for one cycle and counts edges until done; busy must stay high meanwhile.
  task automatic do_run(input logic [3:0] c, output int lat, output logic bsy_ok);
    count  = c;
    go     = 1'b1;
    step();
    go     = 1'b0;
    lat    = 1;
    bsy_ok = 1'b1;
    while (!done && lat < 40) begin
      if (busy !== 1'b1) bsy_ok = 1'b0;
      step();
      lat++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; go = 1'b0; count = '0;
    #12;
    n_tests++; if (result !== 8'h00) begin n_fail++; $display("FAIL reset_result got=%h exp=00", result); end
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b exp=0", busy); end
    n_tests++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done got=%b exp=0", done); end
    step();
    rst = 1'b0;
    step();
    n_tests++; if (busy !== 1'b0 || done !== 1'b0) begin n_fail++; $display("FAIL idle_start got busy=%b done=%b exp 0 0", busy, done); end
  endtask

  task automatic test_count3();
    int lat; logic ok;
    do_run(4'd3, lat, ok);
    n_tests++; if (lat !== 8) begin n_fail++; $display("FAIL c3_latency got=%0d exp=8", lat); end
    n_tests++; if (ok !== 1'b1) begin n_fail++; $display("FAIL c3_busy got=%b exp=1", ok); end
    n_tests++; if (result !== 8'h07) begin n_fail++; $display("FAIL c3_result got=%h exp=07", result); end
    for (int i = 0; i < 4; i++) begin
      step();
      n_tests++;
      if (result !== 8'h07 || done !== 1'b1 || busy !== 1'b0) begin
        n_fail++; $display("FAIL c3_hold got=%h done=%b busy=%b exp=07 1 0", result, done, busy);
      end
    end
  endtask

  task automatic test_zero_and_full();
    int lat; logic ok;
    do_run(4'd0, lat, ok);
    n_tests++; if (lat !== 2) begin n_fail++; $display("FAIL c0_latency got=%0d exp=2", lat); end
    n_tests++; if (result !== 8'h00) begin n_fail++; $display("FAIL c0_result got=%h exp=00", result); end
    do_run(4'd8, lat, ok);
    n_tests++; if (lat !== 18) begin n_fail++; $display("FAIL c8_latency got=%0d exp=18", lat); end
    n_tests++; if (result !== 8'hFF) begin n_fail++; $display("FAIL c8_result got=%h exp=FF", result); end
  endtask

  task automatic test_saturation();
    int lat; logic ok;
    do_run(4'd15, lat, ok);
    n_tests++; if (lat !== 18) begin n_fail++; $display("FAIL c15_latency got=%0d exp=18", lat); end
    n_tests++; if (result !== 8'hFF) begin n_fail++; $display("FAIL c15_result got=%h exp=FF", result); end
    do_run(4'd9, lat, ok);
    n_tests++; if (lat !== 18 || result !== 8'hFF) begin n_fail++; $display("FAIL c9_sat got lat=%0d res=%h exp 18 FF", lat, result); end
  endtask

  task automatic test_ignored_inputs();
    int lat;
    count = 4'd5;
    go    = 1'b1;
    step();
    lat = 1;
    while (!done && lat < 40) begin
      go    = ~go;
      count = 4'($urandom);
      step();
      lat++;
    end
    go = 1'b0;
    n_tests++; if (lat !== 12) begin n_fail++; $display("FAIL ign_latency got=%0d exp=12", lat); end
    n_tests++; if (result !== 8'h1F) begin n_fail++; $display("FAIL ign_result got=%h exp=1F", result); end
  endtask

  task automatic test_back_to_back();
    count = 4'd2;
    go    = 1'b1;
    for (int m = 1; m <= 18; m++) begin
      step();
      n_tests++;
      if (done !== ((m % 6) == 0)) begin
        n_fail++; $display("FAIL b2b_done cycle=%0d got=%b exp=%b", m, done, ((m % 6) == 0));
      end
      if ((m % 6) == 0) begin
        n_tests++;
        if (result !== 8'h03) begin n_fail++; $display("FAIL b2b_result cycle=%0d got=%h exp=03", m, result); end
      end
    end
    go = 1'b0;
    step();
  endtask

  task automatic test_reset_mid();
    int lat; logic ok;
    count = 4'd8;
    go    = 1'b1;
    step();
    go = 1'b0;
    for (int i = 0; i < 5; i++) step();
    n_tests++; if (busy !== 1'b1) begin n_fail++; $display("FAIL mid_busy got=%b exp=1", busy); end
    #3;
    rst = 1'b1;
    #1;
    n_tests++;
    if (result !== 8'h00 || busy !== 1'b0 || done !== 1'b0) begin
      n_fail++; $display("FAIL mid_reset got res=%h busy=%b done=%b exp 00 0 0", result, busy, done);
    end
    step();
    rst = 1'b0;
    do_run(4'd2, lat, ok);
    n_tests++; if (lat !== 6) begin n_fail++; $display("FAIL post_rst_latency got=%0d exp=6", lat); end
    n_tests++; if (result !== 8'h03) begin n_fail++; $display("FAIL post_rst_result got=%h exp=03", result); end
  endtask

  task automatic test_round_trip();
    int lat; logic ok; int n; logic [8:0] therm;
    for (int c = 0; c < 16; c++) begin
      do_run(4'(c), lat, ok);
      n     = (c > 8) ? 8 : c;
      therm = (9'd1 << n) - 9'd1;
      n_tests++; if (lat !== 2 * n + 2) begin n_fail++; $display("FAIL rt_latency c=%0d got=%0d exp=%0d", c, lat, 2 * n + 2); end
      n_tests++; if ($countones(result) !== n) begin n_fail++; $display("FAIL rt_popcount c=%0d got=%0d exp=%0d", c, $countones(result), n); end
      n_tests++; if (result !== therm[7:0]) begin n_fail++; $display("FAIL rt_therm c=%0d got=%h exp=%h", c, result, therm[7:0]); end
      n_tests++; if (ok !== 1'b1) begin n_fail++; $display("FAIL rt_busy c=%0d got=%b exp=1", c, ok); end
    end
  endtask

  initial begin
    test_reset();
    test_count3();
    test_zero_and_full();
    test_saturation();
    test_ignored_inputs();
    test_back_to_back();
    test_reset_mid();
    test_round_trip();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
